// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: oversampling default, FSM state encodings and
// frame shape constants used by both the transmit and receive paths.
package uart_defs;

   localparam int OVERSAMPLE_DEF = 16;
   localparam int DATA_BITS      = 8;
   localparam int STOP_BITS      = 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// rx synchronizer plus a two-deep history of tick samples; maj is the vote of
// the two previous tick samples and the current synced level.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_tick,
   input  logic rx,
   output logic rx_s,
   output logic maj
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [1:0]             hist_q;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
         hist_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         if (sample_tick) hist_q <= {hist_q[0], rx_s};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];
   assign maj  = maj3(hist_q[1], hist_q[0], rx_s);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled 3-sample majority voting, a one-byte
// holding register and sticky frame/overrun status cleared by a read.
module uart_rx
   import uart_defs::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int PH_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_BITS);
   localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   logic [1:0]           state;
   logic [PH_W-1:0]      phase;
   logic [BC_W-1:0]      bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 armed;
   logic                 rx_s;
   logic                 maj;
   logic                 good_frame;
   logic                 bad_frame;
   logic                 ack_hit;

   uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx),
      .rx_s        (rx_s),
      .maj         (maj)
   );

   assign good_frame = sample_tick && (state == ST_STOP) && (phase == PH_LAST) && maj;
   assign bad_frame  = sample_tick && (state == ST_STOP) && (phase == PH_LAST) && !maj;
   assign ack_hit    = rd_ack && data_ready;
   assign busy       = (state != ST_IDLE);

   // armed blocks a restart until the line has been seen high in IDLE (break, reset mid-frame)
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         phase   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         armed   <= 1'b0;
      end else if (sample_tick) begin
         case (state)
            ST_IDLE: begin
               if (rx_s) begin
                  armed <= 1'b1;
               end else if (armed) begin
                  state <= ST_START;
                  phase <= '0;
                  armed <= 1'b0;
               end
            end
            ST_START: begin
               if (phase == PH_MID) begin
                  phase   <= '0;
                  bit_cnt <= '0;
                  state   <= maj ? ST_IDLE : ST_DATA;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_DATA: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
                  shreg <= {maj, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BC_LAST) state <= ST_STOP;
                  else bit_cnt <= bit_cnt + 1'b1;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            ST_STOP: begin
               if (phase == PH_LAST) begin
                  phase <= '0;
                  state <= ST_IDLE;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A load coinciding with rd_ack replaces the consumed byte without flagging overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         data       <= 8'h00;
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (good_frame && (!data_ready || rd_ack)) begin
            data       <= shreg;
            data_ready <= 1'b1;
         end else if (ack_hit) begin
            data_ready <= 1'b0;
         end
         if (good_frame && data_ready && !rd_ack) overrun <= 1'b1;
         else if (ack_hit) overrun <= 1'b0;
         if (bad_frame) frame_err <= 1'b1;
         else if (ack_hit) frame_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: 8N1 frames driven bit by bit, expected bytes
// queued at send time and compared once the frame has been received.
module tb_uart_rx;

   localparam int OS       = 16;
   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = OS * TICK_DIV;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_tick = 1'b0;
   logic       rx = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] data;
   logic       data_ready;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   int         tick_cnt = 0;
   logic       prev_busy = 1'b0;
   logic       prev_dr = 1'b0;
   logic       lat_ok = 1'b0;
   int         ready_rises = 0;

   uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .rx          (rx),
      .rd_ack      (rd_ack),
      .data        (data),
      .data_ready  (data_ready),
      .busy        (busy),
      .frame_err   (frame_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      tick_cnt    = (tick_cnt + 1) % TICK_DIV;
      sample_tick = (tick_cnt == 0);
   end

   // data_ready must rise on the same clk that busy falls (stop-bit sample + 1)
   always @(negedge clk) begin
      if (data_ready && !prev_dr) begin
         lat_ok = prev_busy && !busy;
         ready_rises++;
      end
      prev_dr   = data_ready;
      prev_busy = busy;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input int bclks, input logic stop_val);
      rx = 1'b0;
      wait_clks(bclks);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(bclks);
      end
      rx = stop_val;
      wait_clks(bclks);
      rx = 1'b1;
      wait_clks(bclks);
   endtask

   task automatic pulse_ack;
      rd_ack = 1'b1;
      @(negedge clk);
      rd_ack = 1'b0;
   endtask

   task automatic do_reset;
      rx  = 1'b1;
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      exp_q.delete();
      wait_clks(BIT_CLKS);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx  = 1'b1;
      wait_clks(3);
      n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst = 1'b0;
      wait_clks(BIT_CLKS);
   endtask

   task automatic test_basic;
      logic [7:0] exp;
      do_reset();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, BIT_CLKS, 1'b1);
      exp = exp_q.pop_front();
      n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", data_ready); end
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL basic_data: got %h want %h", data, exp); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL basic_frame_err: got %b want 0", frame_err); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b want 0", overrun); end
      n_checks++; if (lat_ok !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b want 1 (ready with busy fall)", lat_ok); end
      pulse_ack();
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ack_clear: got %b want 0", data_ready); end
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL basic_data_hold: got %h want %h", data, exp); end
   endtask

   task automatic test_overrun;
      logic [7:0] exp;
      do_reset();
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, BIT_CLKS, 1'b1);
      send_frame(8'hC3, BIT_CLKS, 1'b1);
      exp = exp_q.pop_front();
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL ovr_data: got %h want %h", data, exp); end
      n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL ovr_ready: got %b want 1", data_ready); end
      n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      pulse_ack();
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_ready: got %b want 0", data_ready); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b want 0", overrun); end
   endtask

   task automatic test_frame_err;
      logic [7:0] exp;
      do_reset();
      send_frame(8'h55, BIT_CLKS, 1'b0);
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL ferr_ready: got %b want 0", data_ready); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b want 0", busy); end
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, BIT_CLKS, 1'b1);
      exp = exp_q.pop_front();
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL ferr_next_data: got %h want %h", data, exp); end
      n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL ferr_next_ready: got %b want 1", data_ready); end
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
      pulse_ack();
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_ack_clear: got %b want 0", frame_err); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL ferr_ack_ready: got %b want 0", data_ready); end
   endtask

   task automatic test_glitch;
      int  r0;
      bit  dropped;
      do_reset();
      r0 = ready_rises;
      rx = 1'b0;
      wait_clks(3 * TICK_DIV);
      rx = 1'b1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b want 1", busy); end
      dropped = 1'b0;
      for (int t = 0; t < 2 * BIT_CLKS; t++) begin
         if (!busy) begin
            dropped = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_drop: got busy %b want 0 within %0d clks", busy, 2 * BIT_CLKS); end
      wait_clks(BIT_CLKS);
      n_checks++; if (ready_rises !== r0) begin n_fail++; $display("FAIL glitch_no_data: got %0d ready rises want %0d", ready_rises, r0); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_break;
      do_reset();
      rx = 1'b0;
      wait_clks(15 * BIT_CLKS);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_no_restart: got busy %b want 0", busy); end
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_frame_err: got %b want 1", frame_err); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL break_ready: got %b want 0", data_ready); end
      rx = 1'b1;
      wait_clks(BIT_CLKS);
      pulse_ack();
      n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_ack_ignored: got %b want 1", frame_err); end
   endtask

   task automatic test_rst_midframe;
      logic [7:0] exp;
      do_reset();
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         wait_clks(BIT_CLKS);
      end
      rx = 1'b1;
      wait_clks(BIT_CLKS / 2);
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(BIT_CLKS / 2 - 3);
      wait_clks(5 * BIT_CLKS);
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", data_ready); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      exp_q.push_back(8'h81);
      send_frame(8'h81, BIT_CLKS, 1'b1);
      exp = exp_q.pop_front();
      n_checks++; if (data !== exp) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", data, exp); end
      n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_ready: got %b want 1", data_ready); end
      n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
      n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_ferr: got %b want 0", frame_err); end
   endtask

   task automatic test_skew;
      logic [7:0] bytes [2];
      int         clks  [2];
      logic [7:0] exp;
      bytes[0] = 8'h00; clks[0] = 66;
      bytes[1] = 8'hFF; clks[1] = 62;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(bytes[k]);
         send_frame(bytes[k], clks[k], 1'b1);
         exp = exp_q.pop_front();
         n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL skew_ready[%0d]: got %b want 1", k, data_ready); end
         n_checks++; if (data !== exp) begin n_fail++; $display("FAIL skew_data[%0d]: got %h want %h", k, data, exp); end
         n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL skew_frame_err[%0d]: got %b want 0", k, frame_err); end
         pulse_ack();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_frame_err();
      test_glitch();
      test_break();
      test_rst_midframe();
      test_skew();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
